// File: rtl/shift_pkg.sv
// Shared constants and the output-queue entry layout for the shift execute stage.
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 5;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef struct packed {
    logic              illegal;
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] result;
  } q_entry_t;

endpackage

// File: rtl/shift_exec_stage_core.sv
// Combinational shifter: SLL/SRL/SRA on rs by shamt; reserved opcode passes rs through flagged illegal.
module shift_core
  import shift_pkg::*;
#(
  parameter int DATA_W  = shift_pkg::DATA_W,
  parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
  input  logic [DATA_W-1:0]  rs,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic [DATA_W-1:0]  result,
  output logic               illegal
);

  logic [DATA_W-1:0] sra_result;

  // Arithmetic right shift replicates rs[DATA_W-1] into the vacated MSBs.
  assign sra_result = DATA_W'($signed(rs) >>> shamt);

  always_comb begin
    result  = rs;
    illegal = 1'b0;
    case (op)
      OP_SLL:  result = rs << shamt;
      OP_SRL:  result = rs >> shamt;
      OP_SRA:  result = sra_result;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Shift execute stage: valid/ready intake, shift_core, and a 2-entry in-order result queue
// whose head drives the outputs so writeback stalls never drop results.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int DATA_W  = shift_pkg::DATA_W,
  parameter int SHAMT_W = shift_pkg::SHAMT_W,
  parameter int TAG_W   = shift_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic               in_use_reg,
  input  logic [DATA_W-1:0]  in_rs,
  input  logic [DATA_W-1:0]  in_rt,
  input  logic [SHAMT_W-1:0] in_imm_shamt,
  input  logic [TAG_W-1:0]   in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [TAG_W-1:0]   out_rd,
  output logic               out_illegal
);

  logic [1:0]         count;
  logic               rd_ptr;
  logic               wr_ptr;
  q_entry_t           mem [2];
  q_entry_t           head;
  q_entry_t           new_entry;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  core_result;
  logic               core_illegal;
  logic               push;
  logic               pop;
  logic               unused_rt_hi;

  // Only the low shamt bits of the register source matter.
  assign unused_rt_hi = ^in_rt[DATA_W-1:SHAMT_W];
  assign shamt        = in_use_reg ? in_rt[SHAMT_W-1:0] : in_imm_shamt;

  shift_core #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_core (
    .rs      (in_rs),
    .shamt   (shamt),
    .op      (in_op),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign new_entry = '{illegal: core_illegal, rd: in_rd, result: core_result};

  // in_ready is a function of state and reset only; a full queue refuses even when popping.
  assign in_ready  = rst & (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem    <= '{default: '0};
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign out_result  = head.result;
  assign out_rd      = head.rd;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic        in_use_reg = 1'b0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [4:0]  in_imm_shamt = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic        use_reg;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  imm;
    logic [31:0] exp_result;
    logic        exp_illegal;
  } vec_t;

  exp_t       mq[$];
  logic [4:0] popped[$];

  shift_exec_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_use_reg   (in_use_reg),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .in_imm_shamt (in_imm_shamt),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shifts expressed as multiplication / floor division by a power of two.
  function automatic exp_t ref_op(input logic [1:0] op, input logic use_reg, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic [4:0] imm, input logic [4:0] rd);
    exp_t            e;
    int unsigned     sh;
    longint unsigned p;
    longint unsigned m;
    longint          s;
    longint          q;
    sh = use_reg ? (rt % 32) : int'(imm);
    p  = 64'd1 << sh;
    e.rd = rd;
    e.illegal = 1'b0;
    case (op)
      2'b00: begin m = longint'(rs) * p; e.result = m[31:0]; end
      2'b01: begin m = longint'(rs) / p; e.result = m[31:0]; end
      2'b10: begin
        s = longint'($signed(rs));
        q = s / longint'(p);
        if (s < 0 && (s % longint'(p)) != 0) q = q - 1;
        e.result = q[31:0];
      end
      default: begin e.result = rs; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  // One clock cycle: drive at negedge, check state-derived outputs, advance the model at posedge.
  task automatic cyc(input logic r, input logic f, input logic v, input logic [1:0] op,
                     input logic ur, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [4:0] imm, input logic [4:0] rd, input logic ordy);
    logic exp_ready;
    logic do_push;
    logic do_pop;
    exp_t e;
    rst = r; flush = f; in_valid = v; in_op = op; in_use_reg = ur;
    in_rs = rs; in_rt = rt; in_imm_shamt = imm; in_rd = rd; out_ready = ordy;
    #1;
    exp_ready = r && (mq.size() < 2);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("head_result", out_result, mq[0].result);
      chk("head_rd", out_rd, mq[0].rd);
      chk("head_illegal", out_illegal, mq[0].illegal);
    end
    do_push = v && exp_ready && !f;
    do_pop  = (mq.size() > 0) && ordy && !f;
    if (do_pop) popped.push_back(out_rd);
    e = ref_op(op, ur, rs, rt, imm, rd);
    @(posedge clk);
    if (!r || f) begin
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, ordy);
  endtask

  task automatic push_op(input logic [4:0] rd, input logic [31:0] rs, input logic ordy);
    cyc(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, rs, 32'h0, 5'd1, rd, ordy);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_result"}, out_result, 32'h0);
    chk({tag, "_out_rd"}, out_rd, 5'd0);
    chk({tag, "_out_illegal"}, out_illegal, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{2'b10, 1'b0, 32'h8000_0000, 32'h0,        5'd4,  32'hF800_0000, 1'b0};
    vt[1]  = '{2'b01, 1'b0, 32'h8000_0000, 32'h0,        5'd4,  32'h0800_0000, 1'b0};
    vt[2]  = '{2'b01, 1'b0, 32'h8000_0000, 32'h0,        5'd0,  32'h8000_0000, 1'b0};
    vt[3]  = '{2'b00, 1'b1, 32'h0000_0001, 32'hFFFF_FFE3, 5'd17, 32'h0000_0008, 1'b0};
    vt[4]  = '{2'b11, 1'b0, 32'h1234_5678, 32'h0,        5'd9,  32'h1234_5678, 1'b1};
    vt[5]  = '{2'b00, 1'b0, 32'h1234_5678, 32'h0,        5'd4,  32'h2345_6780, 1'b0};
    vt[6]  = '{2'b10, 1'b0, 32'h7FFF_FFFF, 32'h0,        5'd31, 32'h0000_0000, 1'b0};
    vt[7]  = '{2'b10, 1'b0, 32'h8000_0000, 32'h0,        5'd31, 32'hFFFF_FFFF, 1'b0};
    vt[8]  = '{2'b00, 1'b0, 32'h0000_0001, 32'h0,        5'd31, 32'h8000_0000, 1'b0};
    vt[9]  = '{2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0000_003F, 5'd0,  32'h0000_0001, 1'b0};
    vt[10] = '{2'b10, 1'b1, 32'hC000_0000, 32'hFFFF_FFE0, 5'd7,  32'hC000_0000, 1'b0};

    // Reset: hold rst low across two edges, outputs must be zero and in_ready low.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    mq.delete();
    idle(1'b1);

    // Vector table: one op per cycle, each result visible the cycle after its accept.
    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, 1'b0, 1'b1, vt[i].op, vt[i].use_reg, vt[i].rs, vt[i].rt, vt[i].imm, 5'(i), 1'b1);
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_result", i), out_result, vt[i].exp_result);
      chk($sformatf("vec%0d_illegal", i), out_illegal, vt[i].exp_illegal);
    end
    idle(1'b1);
    idle(1'b1);

    // Backpressure: tags 1,2,3 with downstream stalled; tag 3 must wait.
    popped.delete();
    push_op(5'd1, 32'h100, 1'b0);
    push_op(5'd2, 32'h200, 1'b0);
    chk("bp_full_in_ready", in_ready, 1'b0);
    push_op(5'd3, 32'h300, 1'b0);
    chk("bp_hold_in_ready", in_ready, 1'b0);
    push_op(5'd3, 32'h300, 1'b1);
    chk("bp_after_pop_in_ready", in_ready, 1'b1);
    push_op(5'd3, 32'h300, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("bp_pop_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("bp_order0", popped[0], 5'd1);
      chk("bp_order1", popped[1], 5'd2);
      chk("bp_order2", popped[2], 5'd3);
    end

    // Flush with two queued entries and a simultaneous incoming op.
    popped.delete();
    push_op(5'd4, 32'h4, 1'b0);
    push_op(5'd5, 32'h5, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h9, 32'h0, 5'd0, 5'd9, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("flush_nothing_popped", popped.size(), 0);

    // Reset mid-stream, then reset together with flush.
    push_op(5'd6, 32'h6, 1'b0);
    push_op(5'd7, 32'h7, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h0, 5'd0, 5'd8, 1'b1);
    rst = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    cyc(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h8, 32'h0, 5'd0, 5'd8, 1'b1);
    rst = 1'b0;
    #1;
    chk_zero_outputs("rstflush");
    idle(1'b1);
    push_op(5'd10, 32'hA, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk_zero_outputs("rstflush2");
    idle(1'b1);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom_range(0, 59) != 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          $urandom(),
          $urandom(),
          5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)),
          ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
Execute-stage shift unit between decode/operand-fetch and writeback. Accepts one shift micro-op per cycle over a valid/ready handshake and selects the shift amount from the immediate or from a register. Computes SLL/SRL/SRA through a combinational shift core and buffers results in a 2-entry in-order output queue, so writeback stalls do not drop results. Supports pipeline flush for branch squash.

Parameters:
DATA_W, 32, operand/result width
SHAMT_W, 5, shift-amount width (log2 DATA_W)
TAG_W, 5, destination register tag width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
flush  in  1  squash all queued and incoming ops this cycle
in_valid  in  1  upstream op valid
in_ready  out  1  stage can accept an op
in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
in_use_reg  in  1  1: shamt = in_rt[4:0]; 0: shamt = in_imm_shamt
in_rs  in  DATA_W  value to shift
in_rt  in  DATA_W  register shift-amount source
in_imm_shamt  in  SHAMT_W  immediate shift amount
in_rd  in  TAG_W  destination tag
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_result  out  DATA_W  shifted value
out_rd  out  TAG_W  destination tag of out_result
out_illegal  out  1  head op had reserved opcode

Behaviour:
- Reset (rst=0 at an edge): queue count=0, pointers=0, out_valid=0, out_result=0, out_rd=0, out_illegal=0. in_ready=0 while rst=0.
- in_ready = rst & (count<2). Depends only on state; no combinational path from out_ready or in_valid.
- Push when in_valid & in_ready & ~flush. Pop when out_valid & out_ready & ~flush.
- Latency: an op accepted at edge N into an empty queue gives out_valid=1 with its result after edge N. Throughput 1 op/cycle while downstream is ready.
- Queue full (count=2): no push, even with a simultaneous pop. in_ready rises the cycle after the pop.
- Simultaneous push+pop with count=1: count stays 1 and the new entry becomes head.
- Outputs are the registered head entry. out_result/out_rd/out_illegal hold while out_valid & ~out_ready.
- Shift amount: in_use_reg=1 takes in_rt[SHAMT_W-1:0]; upper rt bits are ignored. shamt=0 passes in_rs unchanged.
- SLL zero-fills LSBs. SRL zero-fills MSBs. SRA fills MSBs with in_rs[DATA_W-1].
- Opcode 11: result = in_rs unshifted and out_illegal=1 for that entry. The op is still queued in order.
- flush=1: at the next edge count=0 and out_valid=0. That cycle's input is discarded and the output is not counted as consumed. Data registers may keep stale values.
- flush and rst together: rst wins; the outcome is identical.
- Reset mid-operation: all queued results are lost with no partial output. out_valid=0 the cycle after reset.
- Pointers wrap modulo 2. Ordering is strictly FIFO.

Decomposition:
- Package shift_pkg holds OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_RSVD=2'b11, the DATA_W/SHAMT_W/TAG_W defaults, and the packed queue-entry typedef {illegal, rd, result}.
- One sub-module, shift_core: purely combinational (rs, shamt, op) -> (result, illegal). The existing arithmetic right shifter serves the SRA path inside shift_core.
- Queue, pointers and handshake stay in shift_exec_stage.

Test Plan:
- SRA sign fill: in_rs=0x80000000, imm shamt=4, op=10 -> out_result=0xF8000000, out_valid one cycle after accept.
- SRL zero fill: in_rs=0x80000000, shamt 4, op=01 -> 0x08000000. Same input with shamt=0 -> 0x80000000.
- Register shamt: in_use_reg=1, in_rt=0xFFFFFFE3, in_rs=0x00000001, op=00 -> shamt=3, out_result=0x00000008.
- Backpressure: out_ready=0, issue tags 1,2,3 back-to-back -> in_ready=0 after 2 accepts and tag 3 held upstream. Raise out_ready -> results emerge as tags 1,2,3 in order, none lost or duplicated.
- Reserved op: op=11, in_rs=0x12345678 -> out_result=0x12345678 with out_illegal=1. The next legal op has out_illegal=0.
- Flush/reset: queue 2 entries, pulse flush together with in_valid -> next cycle out_valid=0, count=0, the flushed input is never output. Repeat with rst=0 mid-stream -> all outputs are 0 and in_ready=0 during reset.
